// File: rtl/arc_mem_ctrl_if.sv
// ---------------------------------------------------------------------------
// arc_mem_ctrl_if
//   Memory request/response bundle between the ARC control unit and the
//   main-memory controller.
//
//   Handshake: the master raises RD and/or WR together with Address/Data_In
//   and holds them until it observes ACK_Out. ACK_Out is a one-cycle strobe
//   that marks completion; read data is valid on Data_Out during that cycle.
//   A request level still high once the controller is back in IDLE counts as
//   a new request.
//
//   Signals
//     ArcMemCtrl_RD_In       master -> slave  read request
//     ArcMemCtrl_WR_In       master -> slave  write request
//     ArcMemCtrl_Address_In  master -> slave  byte address
//     ArcMemCtrl_Data_In     master -> slave  write data
//     ArcMemCtrl_Data_Out    slave -> master  read data
//     ArcMemCtrl_ACK_Out     slave -> master  completion strobe
//     ArcMemCtrl_Busy_Out    slave -> master  request in flight
//     ArcMemCtrl_Error_Out   slave -> master  last accepted request illegal
// ---------------------------------------------------------------------------
interface arc_mem_ctrl_if #(
    parameter int DATAWIDTH_BUS = 32
) ();
    logic                     ArcMemCtrl_RD_In;
    logic                     ArcMemCtrl_WR_In;
    logic [DATAWIDTH_BUS-1:0] ArcMemCtrl_Address_In;
    logic [DATAWIDTH_BUS-1:0] ArcMemCtrl_Data_In;
    logic [DATAWIDTH_BUS-1:0] ArcMemCtrl_Data_Out;
    logic                     ArcMemCtrl_ACK_Out;
    logic                     ArcMemCtrl_Busy_Out;
    logic                     ArcMemCtrl_Error_Out;

    modport master (
        output ArcMemCtrl_RD_In,
        output ArcMemCtrl_WR_In,
        output ArcMemCtrl_Address_In,
        output ArcMemCtrl_Data_In,
        input  ArcMemCtrl_Data_Out,
        input  ArcMemCtrl_ACK_Out,
        input  ArcMemCtrl_Busy_Out,
        input  ArcMemCtrl_Error_Out
    );

    modport slave (
        input  ArcMemCtrl_RD_In,
        input  ArcMemCtrl_WR_In,
        input  ArcMemCtrl_Address_In,
        input  ArcMemCtrl_Data_In,
        output ArcMemCtrl_Data_Out,
        output ArcMemCtrl_ACK_Out,
        output ArcMemCtrl_Busy_Out,
        output ArcMemCtrl_Error_Out
    );
endinterface

// File: rtl/arc_mem_ctrl.sv
// ---------------------------------------------------------------------------
// arc_mem_ctrl
//   Main-memory controller for the ARC datapath. Accepts RD/WR requests,
//   spends WAIT_STATES cycles in WAIT, then strobes ACK for one cycle.
//   Word-addressed RAM; misaligned, out-of-range and RD&WR requests are
//   flagged on Error_Out and never touch the RAM or Data_Out.
//
//   Ports
//     ArcMemCtrl_CLOCK_50     system clock, rising edge
//     ArcMemCtrl_RESET_InLow  asynchronous reset, active low
//     bus                     request/response bundle (slave side)
//     dbg_state               current FSM state (0 IDLE, 1 WAIT, 2 ACK)
// ---------------------------------------------------------------------------
module arc_mem_ctrl #(
    parameter int DATAWIDTH_BUS = 32,
    parameter int ADDRWIDTH_MEM = 10,
    parameter int WAIT_STATES   = 2
) (
    input  logic                ArcMemCtrl_CLOCK_50,
    input  logic                ArcMemCtrl_RESET_InLow,
    arc_mem_ctrl_if.slave       bus,
    output logic [1:0]          dbg_state
);
    localparam int DEPTH = 1 << ADDRWIDTH_MEM;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

    state_t state, state_nxt;
    logic [3:0] cnt, cnt_nxt;
    logic       accept, enter_ack;

    logic                     lat_rd, lat_wr, lat_illegal;
    logic [ADDRWIDTH_MEM-1:0] lat_idx;
    logic [DATAWIDTH_BUS-1:0] lat_data;

    logic [DATAWIDTH_BUS-1:0] data_out_q;
    logic                     error_q;
    logic [DATAWIDTH_BUS-1:0] mem [0:DEPTH-1];

    logic                     req, in_illegal;
    logic                     cur_rd, cur_wr, cur_illegal;
    logic [ADDRWIDTH_MEM-1:0] cur_idx;
    logic [DATAWIDTH_BUS-1:0] cur_data;

    assign req = bus.ArcMemCtrl_RD_In | bus.ArcMemCtrl_WR_In;

    // Anything above the RAM's byte span, a non-word address, or both
    // request lines together makes the access illegal.
    assign in_illegal = (bus.ArcMemCtrl_RD_In & bus.ArcMemCtrl_WR_In)
                      | (bus.ArcMemCtrl_Address_In[1:0] != 2'b00)
                      | ((bus.ArcMemCtrl_Address_In >> (ADDRWIDTH_MEM + 2)) != '0);

    // With zero wait states ACK is entered on the accept edge itself, before
    // the request has been latched, so commit uses the live inputs then.
    always_comb begin
        if (state == ST_IDLE) begin
            cur_rd      = bus.ArcMemCtrl_RD_In;
            cur_wr      = bus.ArcMemCtrl_WR_In;
            cur_illegal = in_illegal;
            cur_idx     = bus.ArcMemCtrl_Address_In[ADDRWIDTH_MEM+1:2];
            cur_data    = bus.ArcMemCtrl_Data_In;
        end else begin
            cur_rd      = lat_rd;
            cur_wr      = lat_wr;
            cur_illegal = lat_illegal;
            cur_idx     = lat_idx;
            cur_data    = lat_data;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        accept    = 1'b0;
        enter_ack = 1'b0;
        case (state)
            ST_IDLE: begin
                if (req) begin
                    accept = 1'b1;
                    if (WAIT_STATES == 0) begin
                        state_nxt = ST_ACK;
                        enter_ack = 1'b1;
                    end else begin
                        state_nxt = ST_WAIT;
                        cnt_nxt   = 4'(WAIT_STATES);
                    end
                end
            end
            ST_WAIT: begin
                cnt_nxt = cnt - 4'd1;
                if (cnt <= 4'd1) begin
                    state_nxt = ST_ACK;
                    enter_ack = 1'b1;
                end
            end
            ST_ACK:  state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge ArcMemCtrl_CLOCK_50 or negedge ArcMemCtrl_RESET_InLow) begin
        if (!ArcMemCtrl_RESET_InLow) begin
            state <= ST_IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_ff @(posedge ArcMemCtrl_CLOCK_50 or negedge ArcMemCtrl_RESET_InLow) begin
        if (!ArcMemCtrl_RESET_InLow) begin
            lat_rd      <= 1'b0;
            lat_wr      <= 1'b0;
            lat_illegal <= 1'b0;
            lat_idx     <= '0;
            lat_data    <= '0;
        end else if (accept) begin
            lat_rd      <= bus.ArcMemCtrl_RD_In;
            lat_wr      <= bus.ArcMemCtrl_WR_In;
            lat_illegal <= in_illegal;
            lat_idx     <= bus.ArcMemCtrl_Address_In[ADDRWIDTH_MEM+1:2];
            lat_data    <= bus.ArcMemCtrl_Data_In;
        end
    end

    // Error clears when a legal request is accepted and is set only when an
    // illegal one reaches ACK, so it stays sticky across idle periods.
    always_ff @(posedge ArcMemCtrl_CLOCK_50 or negedge ArcMemCtrl_RESET_InLow) begin
        if (!ArcMemCtrl_RESET_InLow) begin
            error_q    <= 1'b0;
            data_out_q <= '0;
        end else begin
            if (accept && !in_illegal)
                error_q <= 1'b0;
            else if (enter_ack && cur_illegal)
                error_q <= 1'b1;
            if (enter_ack && !cur_illegal && cur_rd)
                data_out_q <= mem[cur_idx];
        end
    end

    // RAM is not reset; writes commit only on the edge entering ACK, so a
    // reset during WAIT leaves memory untouched.
    always_ff @(posedge ArcMemCtrl_CLOCK_50) begin
        if (enter_ack && !cur_illegal && cur_wr)
            mem[cur_idx] <= cur_data;
    end

    assign bus.ArcMemCtrl_Data_Out  = data_out_q;
    assign bus.ArcMemCtrl_Error_Out = error_q;
    assign bus.ArcMemCtrl_ACK_Out   = (state == ST_ACK);
    assign bus.ArcMemCtrl_Busy_Out  = (state != ST_IDLE);
    assign dbg_state                = state;
endmodule

// File: tb/tb_arc_mem_ctrl.sv
// ---------------------------------------------------------------------------
// tb_arc_mem_ctrl
//   Directed bench for arc_mem_ctrl with WAIT_STATES=2, ADDRWIDTH_MEM=10.
// ---------------------------------------------------------------------------
module tb_arc_mem_ctrl;
    localparam int DW = 32;
    localparam int WS = 2;

    logic       clk;
    logic       rst_n;
    logic [1:0] dbg_state;
    int         n_cmp;
    int         n_err;

    arc_mem_ctrl_if #(.DATAWIDTH_BUS(DW)) bus ();

    arc_mem_ctrl #(
        .DATAWIDTH_BUS(DW),
        .ADDRWIDTH_MEM(10),
        .WAIT_STATES  (WS)
    ) dut (
        .ArcMemCtrl_CLOCK_50   (clk),
        .ArcMemCtrl_RESET_InLow(rst_n),
        .bus                   (bus),
        .dbg_state             (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Waits for ACK, returns the number of edges taken (bounded).
    task automatic wait_ack(input string tag, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!bus.ArcMemCtrl_ACK_Out && n < 20);
        if (!bus.ArcMemCtrl_ACK_Out) begin
            n_cmp++;
            n_err++;
            $error("FAIL %s_timeout: observed no ACK expected ACK within 20 cycles", tag);
        end
    endtask

    // Full request: drive, wait for ACK, check latency/error/data, release.
    task automatic do_req(input string tag, input logic rd, input logic wr,
                          input logic [DW-1:0] addr, input logic [DW-1:0] data,
                          input logic exp_err, input logic [DW-1:0] exp_data);
        int n;
        bus.ArcMemCtrl_RD_In      = rd;
        bus.ArcMemCtrl_WR_In      = wr;
        bus.ArcMemCtrl_Address_In = addr;
        bus.ArcMemCtrl_Data_In    = data;
        wait_ack(tag, n);
        check({tag, "_lat"}, 32'(n), 32'(WS + 1));
        check({tag, "_err"}, 32'(bus.ArcMemCtrl_Error_Out), 32'(exp_err));
        check({tag, "_data"}, bus.ArcMemCtrl_Data_Out, exp_data);
        step();
        bus.ArcMemCtrl_RD_In = 1'b0;
        bus.ArcMemCtrl_WR_In = 1'b0;
        check({tag, "_ack_low"}, 32'(bus.ArcMemCtrl_ACK_Out), 32'd0);
    endtask

    initial begin
        int n;
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        bus.ArcMemCtrl_RD_In      = 1'b0;
        bus.ArcMemCtrl_WR_In      = 1'b0;
        bus.ArcMemCtrl_Address_In = '0;
        bus.ArcMemCtrl_Data_In    = '0;
        repeat (3) step();
        rst_n = 1'b1;
        step();

        check("rst_ack",   32'(bus.ArcMemCtrl_ACK_Out),   32'd0);
        check("rst_busy",  32'(bus.ArcMemCtrl_Busy_Out),  32'd0);
        check("rst_err",   32'(bus.ArcMemCtrl_Error_Out), 32'd0);
        check("rst_data",  bus.ArcMemCtrl_Data_Out,       32'd0);
        check("rst_state", 32'(dbg_state),                32'd0);

        // 1: write then read back
        do_req("t1_wr", 1'b1 ^ 1'b1, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0);
        do_req("t1_rd", 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF);

        // 2: misaligned read keeps previous data
        do_req("t2_mis", 1'b1, 1'b0, 32'h12, 32'h0, 1'b1, 32'hDEADBEEF);

        // 3: out-of-range write must not alias word 0; top word legal
        do_req("t3_w0",  1'b0, 1'b1, 32'h0, 32'h11111111, 1'b0, 32'hDEADBEEF);
        do_req("t3_oor", 1'b0, 1'b1, 32'h1000, 32'h1, 1'b1, 32'hDEADBEEF);
        bus.ArcMemCtrl_WR_In      = 1'b1;
        bus.ArcMemCtrl_Address_In = 32'hFFC;
        bus.ArcMemCtrl_Data_In    = 32'hCAFEF00D;
        step();
        check("t3_err_clear_at_accept", 32'(bus.ArcMemCtrl_Error_Out), 32'd0);
        check("t3_busy", 32'(bus.ArcMemCtrl_Busy_Out), 32'd1);
        wait_ack("t3_top_wr", n);
        check("t3_top_wr_lat", 32'(n + 1), 32'(WS + 1));
        step();
        bus.ArcMemCtrl_WR_In = 1'b0;
        do_req("t3_top_rd", 1'b1, 1'b0, 32'hFFC, 32'h0, 1'b0, 32'hCAFEF00D);
        do_req("t3_w0_rd",  1'b1, 1'b0, 32'h0,   32'h0, 1'b0, 32'h11111111);

        // 4: RD&WR illegal, memory untouched
        do_req("t4_rdwr", 1'b1, 1'b1, 32'h10, 32'h0, 1'b1, 32'h11111111);
        do_req("t4_rd",   1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF);

        // 5: reset during WAIT discards the pending write
        do_req("t5_init", 1'b0, 1'b1, 32'h20, 32'hAA, 1'b0, 32'hDEADBEEF);
        bus.ArcMemCtrl_WR_In      = 1'b1;
        bus.ArcMemCtrl_Address_In = 32'h20;
        bus.ArcMemCtrl_Data_In    = 32'h55;
        step();
        step();
        check("t5_in_wait", 32'(dbg_state), 32'd1);
        rst_n = 1'b0;
        #1;
        check("t5_busy_rst", 32'(bus.ArcMemCtrl_Busy_Out), 32'd0);
        check("t5_ack_rst",  32'(bus.ArcMemCtrl_ACK_Out),  32'd0);
        bus.ArcMemCtrl_WR_In = 1'b0;
        repeat (2) begin
            step();
            check("t5_no_ack", 32'(bus.ArcMemCtrl_ACK_Out), 32'd0);
        end
        rst_n = 1'b1;
        step();
        check("t5_data_rst", bus.ArcMemCtrl_Data_Out, 32'd0);
        do_req("t5_rd", 1'b1, 1'b0, 32'h20, 32'h0, 1'b0, 32'hAA);

        // 6: address change during WAIT ignored; back-to-back read
        bus.ArcMemCtrl_RD_In      = 1'b1;
        bus.ArcMemCtrl_Address_In = 32'h10;
        step();
        bus.ArcMemCtrl_Address_In = 32'h20;
        wait_ack("t6_a", n);
        check("t6_a_lat",  32'(n + 1), 32'(WS + 1));
        check("t6_a_data", bus.ArcMemCtrl_Data_Out, 32'hDEADBEEF);
        wait_ack("t6_b", n);
        check("t6_b_lat",  32'(n), 32'(WS + 2));
        check("t6_b_data", bus.ArcMemCtrl_Data_Out, 32'hAA);
        step();
        bus.ArcMemCtrl_RD_In = 1'b0;
        step();
        check("t6_idle", 32'(bus.ArcMemCtrl_Busy_Out), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
